// File: rtl/tick_gen_multi.sv
// rtl/tick_gen_multi.sv - shared prescaler feeding NUM_CH programmable tick/square-wave channels
module tick_gen_multi #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int BASE_HZ = 1000,
    parameter int NUM_CH  = 4,
    parameter int PW      = 16,
    parameter int PER_RST = 1000,
    localparam int WCH    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              en,
    input  logic              sync_clr,
    input  logic              wr_en,
    input  logic [WCH-1:0]    wr_ch,
    input  logic [PW-1:0]     wr_period,
    input  logic              wr_restart,
    output logic              base_tick,
    output logic [NUM_CH-1:0] tick_out,
    output logic [NUM_CH-1:0] sq_out
);

    localparam int DIV = CLK_HZ / BASE_HZ;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0]     pre_cnt_q, pre_cnt_d;
    logic              base_tick_q, base_tick_d;
    logic [PW-1:0]     per_q [NUM_CH];
    logic [PW-1:0]     per_d [NUM_CH];
    logic [PW-1:0]     cnt_q [NUM_CH];
    logic [PW-1:0]     cnt_d [NUM_CH];
    logic [NUM_CH-1:0] tick_q, tick_d;
    logic [NUM_CH-1:0] sq_q, sq_d;
    logic              strobe;
    logic              wr_hit;

    always_comb begin
        strobe      = en && !sync_clr && (pre_cnt_q == CW'(DIV - 1));
        pre_cnt_d   = pre_cnt_q;
        base_tick_d = 1'b0;
        if (sync_clr) begin
            pre_cnt_d = '0;
        end else if (strobe) begin
            pre_cnt_d   = '0;
            base_tick_d = 1'b1;
        end else if (en) begin
            pre_cnt_d = pre_cnt_q + CW'(1);
        end
    end

    // Compare uses per_q, so a write without restart takes effect on the next strobe.
    always_comb begin
        tick_d = '0;
        sq_d   = sq_q;
        wr_hit = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_hit   = wr_en && (wr_ch == WCH'(i));
            per_d[i] = wr_hit ? wr_period : per_q[i];
            cnt_d[i] = cnt_q[i];
            if (sync_clr) begin
                cnt_d[i] = '0;
                sq_d[i]  = 1'b0;
            end else if (wr_hit && wr_restart) begin
                cnt_d[i] = '0;
            end else if (strobe && (per_q[i] != '0)) begin
                // >= keeps a counter bounded when its period shrinks below it
                if (cnt_q[i] >= (per_q[i] - PW'(1))) begin
                    cnt_d[i]  = '0;
                    tick_d[i] = 1'b1;
                    sq_d[i]   = ~sq_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            pre_cnt_q   <= '0;
            base_tick_q <= 1'b0;
            tick_q      <= '0;
            sq_q        <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                per_q[i] <= PW'(PER_RST);
                cnt_q[i] <= '0;
            end
        end else begin
            pre_cnt_q   <= pre_cnt_d;
            base_tick_q <= base_tick_d;
            tick_q      <= tick_d;
            sq_q        <= sq_d;
            for (int i = 0; i < NUM_CH; i++) begin
                per_q[i] <= per_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign base_tick = base_tick_q;
    assign tick_out  = tick_q;
    assign sq_out    = sq_q;

endmodule

// File: tb/tb_tick_gen_multi.sv
// tb/tb_tick_gen_multi.sv - directed bench for tick_gen_multi with DIV=4, two channels, reset period 3
module tb_tick_gen_multi;

    logic       clk_in = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       sync_clr = 1'b0;
    logic       wr_en = 1'b0;
    logic [0:0] wr_ch = '0;
    logic [7:0] wr_period = '0;
    logic       wr_restart = 1'b0;
    logic       base_tick;
    logic [1:0] tick_out;
    logic [1:0] sq_out;

    int tests_run = 0;
    int tests_failed = 0;
    int e = 0;

    tick_gen_multi #(
        .CLK_HZ(20), .BASE_HZ(5), .NUM_CH(2), .PW(8), .PER_RST(3)
    ) dut (
        .clk_in(clk_in), .rst(rst), .en(en), .sync_clr(sync_clr),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_period(wr_period), .wr_restart(wr_restart),
        .base_tick(base_tick), .tick_out(tick_out), .sq_out(sq_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        @(negedge clk_in);
        e++;
    endtask

    task automatic write(input logic ch, input logic [7:0] per, input logic restart);
        wr_en = 1'b1; wr_ch = ch; wr_period = per; wr_restart = restart;
        step();
        wr_en = 1'b0; wr_restart = 1'b0;
    endtask

    task automatic clr();
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        e = 0;
    endtask

    task automatic test_reset();
        step();
        step();
        tests_run++;
        if (base_tick !== 1'b0) begin tests_failed++; $display("FAIL reset_base: got %b expected 0", base_tick); end
        tests_run++;
        if (tick_out !== 2'b00) begin tests_failed++; $display("FAIL reset_tick: got %b expected 00", tick_out); end
        tests_run++;
        if (sq_out !== 2'b00) begin tests_failed++; $display("FAIL reset_sq: got %b expected 00", sq_out); end
    endtask

    task automatic test_basic();
        logic       exp_b;
        logic [1:0] exp_t, exp_s;
        rst = 1'b0;
        e = 0;
        for (int k = 0; k < 24; k++) begin
            step();
            exp_b = (e % 4 == 0);
            exp_t = (e % 12 == 0) ? 2'b11 : 2'b00;
            exp_s = (e >= 12 && e < 24) ? 2'b11 : 2'b00;
            tests_run++;
            if ({base_tick, tick_out, sq_out} !== {exp_b, exp_t, exp_s}) begin
                tests_failed++;
                $display("FAIL basic edge %0d: got b=%b t=%b s=%b expected b=%b t=%b s=%b",
                         e, base_tick, tick_out, sq_out, exp_b, exp_t, exp_s);
            end
        end
    endtask

    task automatic test_period_one();
        logic [1:0] exp_t, exp_s;
        clr();
        write(1'b1, 8'd1, 1'b1);
        for (int k = 0; k < 23; k++) begin
            step();
            exp_t = {(e % 4 == 0), (e % 12 == 0)};
            exp_s = {((e / 4) % 2 == 1), ((e / 12) % 2 == 1)};
            tests_run++;
            if ({tick_out, sq_out} !== {exp_t, exp_s}) begin
                tests_failed++;
                $display("FAIL period_one edge %0d: got t=%b s=%b expected t=%b s=%b",
                         e, tick_out, sq_out, exp_t, exp_s);
            end
        end
    endtask

    task automatic test_halt();
        clr();
        for (int k = 0; k < 12; k++) step();
        tests_run++;
        if (sq_out[0] !== 1'b1) begin tests_failed++; $display("FAIL halt_pre_sq0: got %b expected 1", sq_out[0]); end
        write(1'b0, 8'd0, 1'b0);
        for (int k = 0; k < 80; k++) begin
            step();
            tests_run++;
            if ({tick_out[0], sq_out[0]} !== 2'b01) begin
                tests_failed++;
                $display("FAIL halt_hold edge %0d: got t0=%b s0=%b expected t0=0 s0=1", e, tick_out[0], sq_out[0]);
            end
        end
        write(1'b0, 8'd2, 1'b0);
        for (int k = 0; k < 14; k++) begin
            step();
            tests_run++;
            if (tick_out[0] !== (e == 100 || e == 108)) begin
                tests_failed++;
                $display("FAIL halt_resume edge %0d: got t0=%b expected %b", e, tick_out[0], (e == 100 || e == 108));
            end
        end
    endtask

    task automatic test_shrink();
        clr();
        write(1'b0, 8'd10, 1'b0);
        for (int k = 0; k < 23; k++) begin
            step();
            tests_run++;
            if (tick_out[0] !== 1'b0) begin
                tests_failed++;
                $display("FAIL shrink_long edge %0d: got t0=%b expected 0", e, tick_out[0]);
            end
        end
        write(1'b0, 8'd2, 1'b0);
        for (int k = 0; k < 19; k++) begin
            step();
            tests_run++;
            if (tick_out[0] !== (e == 28 || e == 36 || e == 44)) begin
                tests_failed++;
                $display("FAIL shrink_short edge %0d: got t0=%b expected %b", e, tick_out[0], (e == 28 || e == 36 || e == 44));
            end
        end
    endtask

    task automatic test_enable_clear();
        logic [1:0] exp_t;
        clr();
        for (int k = 0; k < 10; k++) step();
        tests_run++;
        if (sq_out !== 2'b01) begin tests_failed++; $display("FAIL en_pre_sq: got %b expected 01", sq_out); end
        en = 1'b0;
        for (int k = 0; k < 7; k++) begin
            step();
            tests_run++;
            if ({base_tick, tick_out, sq_out} !== 5'b0_00_01) begin
                tests_failed++;
                $display("FAIL en_low edge %0d: got b=%b t=%b s=%b expected b=0 t=00 s=01", e, base_tick, tick_out, sq_out);
            end
        end
        en = 1'b1;
        step();
        tests_run++;
        if (base_tick !== 1'b0) begin tests_failed++; $display("FAIL en_resume_early: got %b expected 0", base_tick); end
        step();
        tests_run++;
        if ({base_tick, tick_out, sq_out} !== 5'b1_10_11) begin
            tests_failed++;
            $display("FAIL en_resume: got b=%b t=%b s=%b expected b=1 t=10 s=11", base_tick, tick_out, sq_out);
        end
        clr();
        tests_run++;
        if ({base_tick, tick_out, sq_out} !== 5'b0) begin
            tests_failed++;
            $display("FAIL sync_clr: got b=%b t=%b s=%b expected all 0", base_tick, tick_out, sq_out);
        end
        for (int k = 0; k < 8; k++) begin
            step();
            exp_t = (e == 4) ? 2'b10 : (e == 8) ? 2'b11 : 2'b00;
            tests_run++;
            if (tick_out !== exp_t) begin
                tests_failed++;
                $display("FAIL clr_keeps_per edge %0d: got %b expected %b", e, tick_out, exp_t);
            end
        end
    endtask

    task automatic test_restart_and_async_reset();
        logic [1:0] exp_t;
        clr();
        write(1'b1, 8'd3, 1'b0);
        for (int k = 0; k < 10; k++) step();
        write(1'b1, 8'd2, 1'b1);
        tests_run++;
        if ({base_tick, tick_out} !== 3'b1_00) begin
            tests_failed++;
            $display("FAIL restart_suppress: got b=%b t=%b expected b=1 t=00", base_tick, tick_out);
        end
        for (int k = 0; k < 8; k++) begin
            step();
            tests_run++;
            if (tick_out[1] !== (e == 20)) begin
                tests_failed++;
                $display("FAIL restart_count edge %0d: got t1=%b expected %b", e, tick_out[1], (e == 20));
            end
        end
        tests_run++;
        if (tick_out !== 2'b10) begin tests_failed++; $display("FAIL pre_async_tick: got %b expected 10", tick_out); end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({base_tick, tick_out, sq_out} !== 5'b0) begin
            tests_failed++;
            $display("FAIL async_reset: got b=%b t=%b s=%b expected all 0", base_tick, tick_out, sq_out);
        end
        @(negedge clk_in);
        rst = 1'b0;
        e = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            exp_t = (e == 12) ? 2'b11 : 2'b00;
            tests_run++;
            if ({base_tick, tick_out} !== {(e % 4 == 0), exp_t}) begin
                tests_failed++;
                $display("FAIL reset_per edge %0d: got b=%b t=%b expected b=%b t=%b", e, base_tick, tick_out, (e % 4 == 0), exp_t);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_period_one();
        test_halt();
        test_shrink();
        test_enable_clear();
        test_restart_and_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
